lsu_lsq_ctrl: RTL and testbench

// - Queue controller driving the per-entry control strobes of the LSU load/store queue: allocates entries in order

---
 rtl/lsu_lsq_ctrl_pkg.sv | 13 +
 rtl/lsu_lsq_ctrl_age_picker.sv | 46 ++++
 rtl/lsu_lsq_ctrl.sv | 134 +++++++++++++
 tb/tb_lsu_lsq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_lsq_ctrl_pkg.sv
// Shared definitions for the LSU load/store queue controller.
//   LSQ_DEPTH_DEF : default number of queue entries (power of two, >= 2)
//   rsp_kind_e    : meaning of the pipeline response replay flag
package lsu_lsq_ctrl_pkg;

    localparam int unsigned LSQ_DEPTH_DEF = 8;

    typedef enum logic {
        RSP_SUCC   = 1'b0,
        RSP_REPLAY = 1'b1
    } rsp_kind_e;

endpackage

// File: rtl/lsu_lsq_ctrl_age_picker.sv
// Age-ordered picker: finds the oldest set bit of a candidate vector, where
// age order starts at the queue head index and wraps around.
//   cand_i     : per-entry candidate flags
//   head_idx_i : index of the oldest entry
//   found_o    : at least one candidate is set
//   idx_o      : index of the oldest candidate ('0 when none)
module lsu_lsq_age_picker
    import lsu_lsq_ctrl_pkg::*;
#(
    parameter  int unsigned LSQ_DEPTH = LSQ_DEPTH_DEF,
    localparam int unsigned LSQ_IDX_W = $clog2(LSQ_DEPTH)
) (
    input  logic [LSQ_DEPTH-1:0] cand_i,
    input  logic [LSQ_IDX_W-1:0] head_idx_i,
    output logic                 found_o,
    output logic [LSQ_IDX_W-1:0] idx_o
);

    logic [LSQ_DEPTH-1:0] rot;
    logic [LSQ_IDX_W-1:0] src;
    logic [LSQ_IDX_W-1:0] enc;

    // Rotate so bit 0 is the head entry; index arithmetic wraps naturally
    // because the depth is a power of two.
    always_comb begin
        rot = '0;
        src = '0;
        for (int unsigned i = 0; i < LSQ_DEPTH; i++) begin
            src    = LSQ_IDX_W'(i) + head_idx_i;
            rot[i] = cand_i[src];
        end
    end

    always_comb begin
        found_o = 1'b0;
        enc     = '0;
        for (int unsigned i = 0; i < LSQ_DEPTH; i++) begin
            if (rot[i] && !found_o) begin
                found_o = 1'b1;
                enc     = LSQ_IDX_W'(i);
            end
        end
        idx_o = found_o ? (enc + head_idx_i) : '0;
    end

endmodule

// File: rtl/lsu_lsq_ctrl.sv
// LSU load/store queue controller. Holds head/tail pointers and drives the
// per-entry control strobes of the entry array.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous pipeline flush, overrides everything
//   enq_*               : in-order allocation from dispatch (tail)
//   ent_*_i             : per-entry status from the entry array
//   ent_*_o             : one-hot per-entry strobes to the entry array
//   iss_*               : oldest-ready issue handshake to the pipeline
//   rsp_*               : pipeline response (success / replay)
//   commit_i            : ROB permits retiring the head entry
//   lsq_cnt_o           : number of occupied entries
module lsu_lsq_ctrl
    import lsu_lsq_ctrl_pkg::*;
#(
    parameter  int unsigned LSQ_DEPTH = LSQ_DEPTH_DEF,
    localparam int unsigned LSQ_IDX_W = $clog2(LSQ_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 enq_vld_i,
    output logic                 enq_rdy_o,
    output logic [LSQ_IDX_W-1:0] enq_idx_o,
    input  logic [LSQ_DEPTH-1:0] ent_vld_i,
    input  logic [LSQ_DEPTH-1:0] ent_awake_i,
    input  logic [LSQ_DEPTH-1:0] ent_exec_i,
    input  logic [LSQ_DEPTH-1:0] ent_succ_i,
    output logic [LSQ_DEPTH-1:0] ent_enq_o,
    output logic [LSQ_DEPTH-1:0] ent_deq_o,
    output logic [LSQ_DEPTH-1:0] ent_exec_o,
    output logic [LSQ_DEPTH-1:0] ent_replay_o,
    output logic [LSQ_DEPTH-1:0] ent_succ_o,
    output logic                 iss_vld_o,
    output logic [LSQ_IDX_W-1:0] iss_idx_o,
    input  logic                 iss_rdy_i,
    input  logic                 rsp_vld_i,
    input  logic [LSQ_IDX_W-1:0] rsp_idx_i,
    input  logic                 rsp_replay_i,
    input  logic                 commit_i,
    output logic [LSQ_IDX_W:0]   lsq_cnt_o
);

    localparam int unsigned PTR_W = LSQ_IDX_W + 1;

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [LSQ_IDX_W-1:0] head_idx, tail_idx;
    logic                 empty, full;
    logic                 enq_fire, deq_fire;
    logic [LSQ_DEPTH-1:0] cand;
    logic                 pick_found;
    logic [LSQ_IDX_W-1:0] pick_idx;

    assign head_idx = head_q[LSQ_IDX_W-1:0];
    assign tail_idx = tail_q[LSQ_IDX_W-1:0];

    // An entry responding this cycle is still marked exec by the array, but
    // it is masked explicitly so a replay cannot be reissued in the same cycle.
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < LSQ_DEPTH; i++) begin
            cand[i] = ent_vld_i[i] & ent_awake_i[i] & ~ent_exec_i[i] & ~ent_succ_i[i]
                    & ~(rsp_vld_i && (rsp_idx_i == LSQ_IDX_W'(i)));
        end
    end

    lsu_lsq_age_picker #(
        .LSQ_DEPTH (LSQ_DEPTH)
    ) u_age_picker (
        .cand_i     (cand),
        .head_idx_i (head_idx),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    always_comb begin
        ent_enq_o    = '0;
        ent_deq_o    = '0;
        ent_exec_o   = '0;
        ent_replay_o = '0;
        ent_succ_o   = '0;

        empty     = (head_q == tail_q);
        full      = (head_idx == tail_idx) && (head_q[LSQ_IDX_W] != tail_q[LSQ_IDX_W]);
        lsq_cnt_o = tail_q - head_q;
        enq_idx_o = tail_idx;

        // Full is evaluated on current state only: a same-cycle dequeue
        // does not open a slot.
        enq_rdy_o = ~full & ~flush;
        enq_fire  = enq_vld_i & enq_rdy_o;
        deq_fire  = ~flush & commit_i & ~empty & ent_vld_i[head_idx] & ent_succ_i[head_idx];

        iss_vld_o = pick_found & ~flush;
        iss_idx_o = iss_vld_o ? pick_idx : '0;

        if (enq_fire) begin
            ent_enq_o[tail_idx] = 1'b1;
        end
        if (deq_fire) begin
            ent_deq_o[head_idx] = 1'b1;
        end
        if (iss_vld_o && iss_rdy_i) begin
            ent_exec_o[iss_idx_o] = 1'b1;
        end
        if (!flush && rsp_vld_i && ent_vld_i[rsp_idx_i]) begin
            if (rsp_kind_e'(rsp_replay_i) == RSP_REPLAY) begin
                ent_replay_o[rsp_idx_i] = 1'b1;
            end else begin
                ent_succ_o[rsp_idx_i] = 1'b1;
            end
        end

        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PTR_W'(deq_fire);
            tail_d = tail_q + PTR_W'(enq_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: tb/tb_lsu_lsq_ctrl.sv
module tb_lsu_lsq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       enq_vld_i;
    logic       enq_rdy_o;
    logic [2:0] enq_idx_o;
    logic [7:0] ent_vld_i, ent_awake_i, ent_exec_i, ent_succ_i;
    logic [7:0] ent_enq_o, ent_deq_o, ent_exec_o, ent_replay_o, ent_succ_o;
    logic       iss_vld_o;
    logic [2:0] iss_idx_o;
    logic       iss_rdy_i;
    logic       rsp_vld_i;
    logic [2:0] rsp_idx_i;
    logic       rsp_replay_i;
    logic       commit_i;
    logic [3:0] lsq_cnt_o;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    lsu_lsq_ctrl #(
        .LSQ_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .enq_vld_i    (enq_vld_i),
        .enq_rdy_o    (enq_rdy_o),
        .enq_idx_o    (enq_idx_o),
        .ent_vld_i    (ent_vld_i),
        .ent_awake_i  (ent_awake_i),
        .ent_exec_i   (ent_exec_i),
        .ent_succ_i   (ent_succ_i),
        .ent_enq_o    (ent_enq_o),
        .ent_deq_o    (ent_deq_o),
        .ent_exec_o   (ent_exec_o),
        .ent_replay_o (ent_replay_o),
        .ent_succ_o   (ent_succ_o),
        .iss_vld_o    (iss_vld_o),
        .iss_idx_o    (iss_idx_o),
        .iss_rdy_i    (iss_rdy_i),
        .rsp_vld_i    (rsp_vld_i),
        .rsp_idx_i    (rsp_idx_i),
        .rsp_replay_i (rsp_replay_i),
        .commit_i     (commit_i),
        .lsq_cnt_o    (lsq_cnt_o)
    );

    typedef struct {
        // stimulus
        logic       enq;
        logic [7:0] vld, awake, exec, succ;
        logic       rdy, rspv;
        logic [2:0] rspi;
        logic       rep, commit;
        // expected
        logic       e_rdy;
        logic [2:0] e_eidx;
        logic [7:0] e_enq, e_deq, e_exec, e_rep, e_succ;
        logic       e_issv;
        logic [2:0] e_issi;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        enq_vld_i    = 1'b0;
        ent_vld_i    = '0;
        ent_awake_i  = '0;
        ent_exec_i   = '0;
        ent_succ_i   = '0;
        iss_rdy_i    = 1'b0;
        rsp_vld_i    = 1'b0;
        rsp_idx_i    = '0;
        rsp_replay_i = 1'b0;
        commit_i     = 1'b0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 2ns later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic enq_n(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            idle();
            enq_vld_i = 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic pulse_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            enq vld    awake  exec   succ   rdy  rspv rspi rep  cmt | rdy  eidx  enq    deq    exec   rep    succ   issv issi cnt
        vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd0};
        vecs[1]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd0};
        vecs[2]  = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd1};
        vecs[3]  = '{1'b1, 8'h03, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'h00, 8'h02, 8'h00, 8'h00, 1'b1, 3'd1, 4'd2};
        vecs[4]  = '{1'b0, 8'h07, 8'h07, 8'h02, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3'd0, 4'd3};
        vecs[5]  = '{1'b0, 8'h07, 8'h07, 8'h02, 8'h00, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 1'b1, 3'd0, 4'd3};
        vecs[6]  = '{1'b0, 8'h07, 8'h07, 8'h01, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 1'b1, 3'd1, 4'd3};
        vecs[7]  = '{1'b0, 8'h07, 8'h07, 8'h06, 8'h01, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd3};
        vecs[8]  = '{1'b0, 8'h06, 8'h06, 8'h06, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd2};
        vecs[9]  = '{1'b1, 8'h06, 8'h06, 8'h06, 8'h02, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd2};
        vecs[10] = '{1'b0, 8'h0C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 4'd2};
        vecs[11] = '{1'b0, 8'h0C, 8'h0C, 8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 3'd4, 8'h00, 8'h00, 8'h08, 8'h04, 8'h00, 1'b1, 3'd3, 4'd2};

        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence: alloc, issue, replay, success, commit.
        for (int unsigned v = 0; v < 12; v++) begin
            enq_vld_i    = vecs[v].enq;
            ent_vld_i    = vecs[v].vld;
            ent_awake_i  = vecs[v].awake;
            ent_exec_i   = vecs[v].exec;
            ent_succ_i   = vecs[v].succ;
            iss_rdy_i    = vecs[v].rdy;
            rsp_vld_i    = vecs[v].rspv;
            rsp_idx_i    = vecs[v].rspi;
            rsp_replay_i = vecs[v].rep;
            commit_i     = vecs[v].commit;
            #2;
            chk($sformatf("v%0d enq_rdy", v),    32'(enq_rdy_o),    32'(vecs[v].e_rdy));
            chk($sformatf("v%0d enq_idx", v),    32'(enq_idx_o),    32'(vecs[v].e_eidx));
            chk($sformatf("v%0d ent_enq", v),    32'(ent_enq_o),    32'(vecs[v].e_enq));
            chk($sformatf("v%0d ent_deq", v),    32'(ent_deq_o),    32'(vecs[v].e_deq));
            chk($sformatf("v%0d ent_exec", v),   32'(ent_exec_o),   32'(vecs[v].e_exec));
            chk($sformatf("v%0d ent_replay", v), 32'(ent_replay_o), 32'(vecs[v].e_rep));
            chk($sformatf("v%0d ent_succ", v),   32'(ent_succ_o),   32'(vecs[v].e_succ));
            chk($sformatf("v%0d iss_vld", v),    32'(iss_vld_o),    32'(vecs[v].e_issv));
            chk($sformatf("v%0d iss_idx", v),    32'(iss_idx_o),    32'(vecs[v].e_issi));
            chk($sformatf("v%0d cnt", v),        32'(lsq_cnt_o),    32'(vecs[v].e_cnt));
            tick();
        end

        // Asynchronous reset in mid-cycle with 3 entries queued.
        enq_n(1);
        #2;
        chk("rst pre cnt", 32'(lsq_cnt_o), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst cnt",     32'(lsq_cnt_o), 32'd0);
        chk("rst enq_rdy", 32'(enq_rdy_o), 32'd1);
        chk("rst enq_idx", 32'(enq_idx_o), 32'd0);
        chk("rst iss_vld", 32'(iss_vld_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full; the ninth offer is refused.
        for (int unsigned k = 0; k < 8; k++) begin
            idle();
            enq_vld_i = 1'b1;
            #2;
            chk($sformatf("fill%0d enq_idx", k), 32'(enq_idx_o), k);
            chk($sformatf("fill%0d ent_enq", k), 32'(ent_enq_o), 32'd1 << k);
            tick();
        end
        enq_vld_i = 1'b1;
        #2;
        chk("full cnt",     32'(lsq_cnt_o), 32'd8);
        chk("full enq_rdy", 32'(enq_rdy_o), 32'd0);
        chk("full ent_enq", 32'(ent_enq_o), 32'd0);
        tick();
        #2;
        chk("full hold cnt", 32'(lsq_cnt_o), 32'd8);

        // Retire 7 entries, refill to full with head at 7, then commit + enqueue.
        for (int unsigned k = 0; k < 7; k++) begin
            idle();
            ent_vld_i  = 8'hFF;
            ent_succ_i = 8'd1 << k;
            commit_i   = 1'b1;
            #2;
            chk($sformatf("drain%0d ent_deq", k), 32'(ent_deq_o), 32'd1 << k);
            tick();
        end
        idle();
        #2;
        chk("drain cnt", 32'(lsq_cnt_o), 32'd1);
        for (int unsigned k = 0; k < 7; k++) begin
            idle();
            enq_vld_i = 1'b1;
            #2;
            chk($sformatf("refill%0d enq_idx", k), 32'(enq_idx_o), k);
            tick();
        end
        idle();
        enq_vld_i  = 1'b1;
        commit_i   = 1'b1;
        ent_vld_i  = 8'hFF;
        ent_succ_i = 8'h80;
        #2;
        chk("wrap cnt",     32'(lsq_cnt_o), 32'd8);
        chk("wrap ent_deq", 32'(ent_deq_o), 32'h80);
        chk("wrap ent_enq", 32'(ent_enq_o), 32'h00);
        chk("wrap enq_rdy", 32'(enq_rdy_o), 32'd0);
        tick();
        idle();
        enq_vld_i = 1'b1;
        #2;
        chk("wrap2 cnt",     32'(lsq_cnt_o), 32'd7);
        chk("wrap2 enq_rdy", 32'(enq_rdy_o), 32'd1);
        chk("wrap2 enq_idx", 32'(enq_idx_o), 32'd7);
        chk("wrap2 ent_enq", 32'(ent_enq_o), 32'h80);
        tick();
        idle();
        #2;
        chk("wrap3 cnt", 32'(lsq_cnt_o), 32'd8);

        // Age pick across the wrap: head=6, entries 6,7,0 valid, 7 and 0 awake.
        pulse_reset();
        enq_n(6);
        for (int unsigned k = 0; k < 6; k++) begin
            idle();
            ent_vld_i  = 8'hFF;
            ent_succ_i = 8'hFF;
            commit_i   = 1'b1;
            tick();
        end
        enq_n(3);
        ent_vld_i   = 8'hC1;
        ent_awake_i = 8'h81;
        iss_rdy_i   = 1'b1;
        #2;
        chk("age cnt",      32'(lsq_cnt_o),  32'd3);
        chk("age iss_vld",  32'(iss_vld_o),  32'd1);
        chk("age iss_idx",  32'(iss_idx_o),  32'd7);
        chk("age ent_exec", 32'(ent_exec_o), 32'h80);
        tick();
        ent_exec_i = 8'h80;
        #2;
        chk("age2 iss_idx",  32'(iss_idx_o),  32'd0);
        chk("age2 ent_exec", 32'(ent_exec_o), 32'h01);
        tick();

        // Flush with 5 entries and every other request pending.
        enq_n(2);
        enq_vld_i    = 1'b1;
        ent_vld_i    = 8'hC7;
        ent_awake_i  = 8'hFF;
        ent_succ_i   = 8'h40;
        iss_rdy_i    = 1'b1;
        rsp_vld_i    = 1'b1;
        rsp_idx_i    = 3'd7;
        commit_i     = 1'b1;
        #2;
        chk("pre-flush cnt",  32'(lsq_cnt_o), 32'd5);
        chk("pre-flush deq",  32'(ent_deq_o), 32'h40);
        flush = 1'b1;
        #1;
        chk("flush strobes", 32'({ent_enq_o, ent_deq_o, ent_exec_o, ent_replay_o}), 32'd0);
        chk("flush succ",    32'(ent_succ_o), 32'd0);
        chk("flush iss_vld", 32'(iss_vld_o),  32'd0);
        chk("flush iss_idx", 32'(iss_idx_o),  32'd0);
        chk("flush enq_rdy", 32'(enq_rdy_o),  32'd0);
        tick();
        idle();
        #2;
        chk("post-flush cnt",     32'(lsq_cnt_o), 32'd0);
        chk("post-flush enq_idx", 32'(enq_idx_o), 32'd0);
        chk("post-flush enq_rdy", 32'(enq_rdy_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
